io_store_capture: RTL and testbench

IO_STORE_CAPTURE -- requirements
Module: io_store_capture

---
 rtl/mips_io_pkg.sv | 6 +
 rtl/hist_buffer.sv | 34 +++
 rtl/io_store_capture.sv | 78 +++++++
 tb/tb_io_store_capture.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mips_io_pkg.sv
// mips_io_pkg: shared defaults and display mode type for the store-capture display path
package mips_io_pkg;
  localparam logic [31:0] DISP_ADDR_DEF = 32'h0000_0054;
  localparam int HIST_DEPTH_DEF = 8;
  typedef enum logic {LIVE, BROWSE} mode_t;
endpackage

// File: rtl/hist_buffer.sv
// hist_buffer: circular history of captured values with one combinational read port addressed back from the newest entry
module hist_buffer #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] rd_off,
  output logic [31:0]   rdata,
  output logic [AW:0]   count
);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  // storage is not reset; only entries below count carry meaning
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= wdata;
  // pointer wraps on power-of-two depth, count saturates once the oldest entry starts being overwritten
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      count <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + AW'(1);
      count <= (count == (AW+1)'(DEPTH)) ? count : count + (AW+1)'(1);
    end
  // offset 0 is the newest entry, offset n the n-th older one
  always_comb begin
    rd_ptr = wr_ptr - rd_off - AW'(1);
    rdata = mem[rd_ptr];
  end
endmodule

// File: rtl/io_store_capture.sv
// io_store_capture: captures core stores to the display address, keeps a browsable history and drives the display registers
module io_store_capture
  import mips_io_pkg::*;
#(
  parameter logic [31:0] DISP_ADDR = DISP_ADDR_DEF,
  parameter int HIST_DEPTH = HIST_DEPTH_DEF,
  localparam int AW = $clog2(HIST_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          step,
  input  logic          resume,
  output logic [31:0]   disp_value,
  output logic [AW-1:0] disp_index,
  output logic          browse,
  output logic [AW:0]   hist_count,
  output logic          pending,
  output logic [15:0]   write_count
);
  mode_t mode;
  logic [31:0] live_value;
  logic [31:0] rdata;
  logic cap;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] rd_off;
  // capture decode and the history entry a step would show next
  always_comb begin
    cap = memwrite && (dataadr == DISP_ADDR);
    next_idx = (({1'b0, disp_index} + (AW+1)'(1)) == hist_count) ? '0 : disp_index + AW'(1);
    rd_off = (mode == LIVE) ? '0 : next_idx;
    browse = (mode == BROWSE);
  end
  hist_buffer #(.DEPTH(HIST_DEPTH)) u_hist (
    .clk(clk),
    .reset(reset),
    .we(cap && mode == LIVE),
    .wdata(writedata),
    .rd_off(rd_off),
    .rdata(rdata),
    .count(hist_count)
  );
  // mode machine with live register, capture counter and registered display outputs; resume wins over step
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode <= LIVE;
      live_value <= '0;
      write_count <= '0;
      disp_value <= '0;
      disp_index <= '0;
      pending <= 1'b0;
    end else begin
      if (cap) begin
        live_value <= writedata;
        write_count <= write_count + 16'd1;
      end
      if (resume) begin
        mode <= LIVE;
        pending <= 1'b0;
        disp_index <= '0;
        disp_value <= cap ? writedata : live_value;
      end else if (mode == LIVE) begin
        if (step && hist_count != '0) begin
          mode <= BROWSE;
          disp_index <= '0;
          disp_value <= rdata;
        end else if (cap) disp_value <= writedata;
      end else begin
        if (cap) pending <= 1'b1;
        if (step) begin
          disp_index <= next_idx;
          disp_value <= rdata;
        end
      end
    end
endmodule

// File: tb/tb_io_store_capture.sv
// tb_io_store_capture: vector-table and scoreboard bench for the store-capture display block
module tb_io_store_capture;
  typedef struct packed {
    logic [31:0] v;
    logic [2:0]  idx;
    logic        br;
    logic [3:0]  hc;
    logic        pend;
    logic [15:0] wc;
  } out_t;
  typedef struct packed {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        st;
    logic        rs;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic step = 1'b0;
  logic resume = 1'b0;
  logic [31:0] disp_value;
  logic [2:0] disp_index;
  logic browse;
  logic [3:0] hist_count;
  logic pending;
  logic [15:0] write_count;

  int n_checks = 0;
  int n_fail = 0;
  out_t exp_q[$];

  io_store_capture dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .dataadr(dataadr),
    .writedata(writedata),
    .step(step),
    .resume(resume),
    .disp_value(disp_value),
    .disp_index(disp_index),
    .browse(browse),
    .hist_count(hist_count),
    .pending(pending),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  function automatic out_t o(input logic [31:0] v, input int idx, input logic br, input int hc, input logic p, input int wc);
    o = '{v: v, idx: 3'(idx), br: br, hc: 4'(hc), pend: p, wc: 16'(wc)};
  endfunction

  function automatic vec_t vc(input logic mw, input logic [31:0] adr, input logic [31:0] wd, input logic st, input logic rs, input out_t e);
    vc = '{mw: mw, adr: adr, wd: wd, st: st, rs: rs, exp: e};
  endfunction

  task automatic compare(input string name);
    out_t got;
    out_t e;
    got = '{v: disp_value, idx: disp_index, br: browse, hc: hist_count, pend: pending, wc: write_count};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got v=%h idx=%0d br=%b hc=%0d pend=%b wc=%0d, expected v=%h idx=%0d br=%b hc=%0d pend=%b wc=%0d",
               name, got.v, got.idx, got.br, got.hc, got.pend, got.wc, e.v, e.idx, e.br, e.hc, e.pend, e.wc);
    end
  endtask

  task automatic apply(input vec_t t, input string name);
    memwrite = t.mw;
    dataadr = t.adr;
    writedata = t.wd;
    step = t.st;
    resume = t.rs;
    exp_q.push_back(t.exp);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    step = 1'b0;
    resume = 1'b0;
    compare(name);
  endtask

  localparam logic [31:0] A = 32'h54;
  vec_t tbl [8];

  initial begin
    tbl[0] = vc(0, A, 0, 1, 0, o(0, 0, 0, 0, 0, 0));
    tbl[1] = vc(1, A, 7, 0, 0, o(7, 0, 0, 1, 0, 1));
    tbl[2] = vc(1, 32'h50, 99, 0, 0, o(7, 0, 0, 1, 0, 1));
    tbl[3] = vc(0, A, 55, 0, 0, o(7, 0, 0, 1, 0, 1));
    tbl[4] = vc(0, A, 0, 1, 1, o(7, 0, 0, 1, 0, 1));
    tbl[5] = vc(0, A, 0, 1, 0, o(7, 0, 1, 1, 0, 1));
    tbl[6] = vc(0, A, 0, 1, 0, o(7, 0, 1, 1, 0, 1));
    tbl[7] = vc(0, A, 0, 0, 1, o(7, 0, 0, 1, 0, 1));
    exp_q.push_back(o(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    compare("reset_state");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));
    for (int k = 1; k <= 10; k++)
      apply(vc(1, A, k, 0, 0, o(k, 0, 0, (k + 1 > 8) ? 8 : k + 1, 0, k + 1)), $sformatf("fill%0d", k));
    for (int i = 0; i <= 8; i++)
      apply(vc(0, A, 0, 1, 0, o(10 - (i % 8), i % 8, 1, 8, 0, 11)), $sformatf("browse_step%0d", i));
    apply(vc(1, A, 32'hABCD, 0, 0, o(10, 0, 1, 8, 1, 12)), "browse_capture");
    apply(vc(0, A, 0, 0, 1, o(32'hABCD, 0, 0, 8, 0, 12)), "resume_live");
    apply(vc(0, A, 0, 1, 0, o(10, 0, 1, 8, 0, 12)), "frozen_newest");
    apply(vc(0, A, 0, 1, 0, o(9, 1, 1, 8, 0, 12)), "frozen_next");
    apply(vc(0, A, 0, 1, 1, o(32'hABCD, 0, 0, 8, 0, 12)), "step_resume_same_edge");
    apply(vc(1, A, 32'h77, 1, 0, o(10, 0, 1, 8, 0, 13)), "capture_with_step");
    apply(vc(0, A, 0, 1, 0, o(10, 1, 1, 8, 0, 13)), "after_capture_step");
    apply(vc(1, A, 32'h88, 0, 1, o(32'h88, 0, 0, 8, 0, 14)), "resume_with_capture");
    apply(vc(0, A, 0, 1, 0, o(32'h77, 0, 1, 8, 0, 14)), "history_unchanged");
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.push_back(o(0, 0, 0, 0, 0, 0));
    #1;
    compare("async_reset_mid_browse");
    @(negedge clk);
    reset = 1'b1;
    apply(vc(1, A, 5, 0, 0, o(5, 0, 0, 1, 0, 1)), "first_edge_capture");
    apply(vc(0, A, 0, 1, 0, o(5, 0, 1, 1, 0, 1)), "single_entry_browse");
    apply(vc(0, A, 0, 1, 0, o(5, 0, 1, 1, 0, 1)), "single_entry_wrap");
    apply(vc(1, 32'h50, 9, 0, 1, o(5, 0, 0, 1, 0, 1)), "resume_other_addr");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
